// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, constants and match helpers for the hazard unit.
//   FWD_REG / FWD_WB / FWD_MEM : execute operand mux select codes
//   REG_ZERO                   : hard-wired zero register index
//   shadow_t                   : per-stage record {valid, rd, reg_write, mem_read}
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;
  localparam int unsigned CNT_W = 32;

  localparam logic [FWD_W-1:0] FWD_REG = FWD_W'(0);
  localparam logic [FWD_W-1:0] FWD_WB  = FWD_W'(1);
  localparam logic [FWD_W-1:0] FWD_MEM = FWD_W'(2);

  localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } shadow_t;

  // True when the shadowed instruction produces the register a used source reads.
  function automatic logic src_match(input shadow_t s, input logic [REG_W-1:0] src,
                                     input logic used);
    return s.valid & s.reg_write & (s.rd != REG_ZERO) & (s.rd == src) & used;
  endfunction

  // Forward select for one operand; the nearer (EX) producer takes priority.
  function automatic logic [FWD_W-1:0] fwd_sel(input shadow_t ex, input shadow_t mem,
                                               input logic [REG_W-1:0] src, input logic used);
    logic [FWD_W-1:0] sel;
    sel = FWD_REG;
    if (src_match(ex, src, used)) begin
      sel = FWD_MEM;
    end else if (src_match(mem, src, used)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_shadow_reg.sv
// hazard_shadow_reg: one pipeline shadow stage.
//   clk, clr : clock, synchronous active-high clear
//   squash   : load an empty slot instead of d
//   d, q     : incoming / held stage record
module hazard_shadow_reg
  import hazard_pkg::*;
(
  input  logic    clk,
  input  logic    clr,
  input  logic    squash,
  input  shadow_t d,
  output shadow_t q
);

  // An inserted bubble is an all-zero record so it can never match a source.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (squash) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding-select and load-use stall generator for a 5-stage pipe.
//   clk, clr             : clock, synchronous active-high reset
//   id_*                 : decode-stage instruction fields
//   flush                : branch taken, squash the decode instruction
//   ForwardA, ForwardB   : registered operand mux selects for execute
//   stall                : combinational, hold PC and IF/ID this cycle
//   bubble               : registered, execute holds a squashed instruction
//   stall_count          : saturating stall-cycle counter (HAZARD_STATS_EN only)
module hazard_unit
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             flush,
  output logic [FWD_W-1:0] ForwardA,
  output logic [FWD_W-1:0] ForwardB,
  output logic             stall,
  output logic             bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);

  shadow_t id_fields;
  shadow_t ex_q;
  shadow_t mem_q;
  shadow_t wb_q;
  logic    squash;

  logic [FWD_W-1:0] fwd_a_d;
  logic [FWD_W-1:0] fwd_b_d;
  logic             bubble_d;

  // Decode fields packed into a shadow record.
  always_comb begin
    id_fields           = '0;
    id_fields.valid     = id_valid;
    id_fields.rd        = id_rd;
    id_fields.reg_write = id_RegWrite;
    id_fields.mem_read  = id_MemRead;
  end

  // Load-use detection against the instruction now in execute; flush overrides.
  always_comb begin
    stall = 1'b0;
    if (id_valid && !flush && ex_q.valid && ex_q.mem_read) begin
      stall = src_match(ex_q, id_rs1, id_use_rs1) | src_match(ex_q, id_rs2, id_use_rs2);
    end
  end

  assign squash = stall | flush;

  hazard_shadow_reg u_ex (
    .clk    (clk),
    .clr    (clr),
    .squash (squash),
    .d      (id_fields),
    .q      (ex_q)
  );

  hazard_shadow_reg u_mem (
    .clk    (clk),
    .clr    (clr),
    .squash (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  hazard_shadow_reg u_wb (
    .clk    (clk),
    .clr    (clr),
    .squash (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  // WB is tracked for occupancy only; the register file handles write-then-read.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  // Next-cycle output values: EX producer is one stage ahead by the time decode
  // reaches execute, so it is taken from memory; MEM producer from writeback.
  always_comb begin
    fwd_a_d  = FWD_REG;
    fwd_b_d  = FWD_REG;
    bubble_d = 1'b1;
    if (!squash) begin
      fwd_a_d  = fwd_sel(ex_q, mem_q, id_rs1, id_use_rs1);
      fwd_b_d  = fwd_sel(ex_q, mem_q, id_rs2, id_use_rs2);
      bubble_d = ~id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ForwardA <= FWD_REG;
      ForwardB <= FWD_REG;
      bubble   <= 1'b1;
    end else begin
      ForwardA <= fwd_a_d;
      ForwardB <= fwd_b_d;
      bubble   <= bubble_d;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (clr) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vector table, clear-during-stall sequence and
// randomized stimulus against a pipeline-occupancy reference model.
module tb_hazard_unit;

  logic       clk;
  logic       clr;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_RegWrite;
  logic       id_MemRead;
  logic       flush;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic       stall;
  logic       bubble;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count;
`endif

  hazard_unit dut (
    .clk         (clk),
    .clr         (clr),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_RegWrite (id_RegWrite),
    .id_MemRead  (id_MemRead),
    .flush       (flush),
    .ForwardA    (ForwardA),
    .ForwardB    (ForwardB),
    .stall       (stall),
    .bubble      (bubble)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       clr;
    bit       idv;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       u1;
    bit       u2;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
    bit       fl;
    bit       est;
    bit [1:0] efa;
    bit [1:0] efb;
    bit       ebub;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: the instructions occupying EX (0), MEM (1), WB (2).
  bit     m_v  [3];
  int     m_rd [3];
  bit     m_rw [3];
  bit     m_mr [3];
  longint m_cnt = 0;

  function automatic vec_t mk(bit c, bit idv, int rs1, int rs2, bit u1, bit u2, int rd,
                              bit rw, bit mr, bit fl, bit est, int efa, int efb, bit ebub);
    vec_t v;
    v.clr = c;   v.idv = idv; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.u1  = u1;  v.u2  = u2;  v.rd  = 5'(rd);  v.rw  = rw; v.mr = mr; v.fl = fl;
    v.est = est; v.efa = 2'(efa); v.efb = 2'(efb); v.ebub = ebub;
    return v;
  endfunction

  function automatic bit writes(int k, int src);
    return m_v[k] && m_rw[k] && (m_rd[k] != 0) && (m_rd[k] == src);
  endfunction

  function automatic bit model_stall(vec_t v);
    if (!v.idv || v.fl) return 1'b0;
    if (!(m_v[0] && m_mr[0])) return 1'b0;
    return (v.u1 && writes(0, int'(v.rs1))) || (v.u2 && writes(0, int'(v.rs2)));
  endfunction

  // Code 2 when the producer is one instruction ahead, 1 when two ahead.
  function automatic int model_fwd(int src, bit used);
    if (!used) return 0;
    for (int k = 0; k < 2; k++) begin
      if (writes(k, src)) return 2 - k;
    end
    return 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock: drive, check stall, advance, check registered outputs.
  task automatic step(input vec_t v, input bit tab, input string tag);
    bit est;
    bit squash;
    int nfa;
    int nfb;
    bit nbub;
    clr = v.clr; id_valid = v.idv; id_rs1 = v.rs1; id_rs2 = v.rs2;
    id_use_rs1 = v.u1; id_use_rs2 = v.u2; id_rd = v.rd;
    id_RegWrite = v.rw; id_MemRead = v.mr; flush = v.fl;
    #1;
    est = model_stall(v);
    check($sformatf("%s stall", tag), 64'(stall), 64'(tab ? v.est : est));
    if (v.clr) begin
      for (int k = 0; k < 3; k++) begin
        m_v[k] = 0; m_rd[k] = 0; m_rw[k] = 0; m_mr[k] = 0;
      end
      nfa = 0; nfb = 0; nbub = 1; m_cnt = 0;
    end else begin
      squash = est || v.fl;
      nfa = squash ? 0 : model_fwd(int'(v.rs1), v.u1);
      nfb = squash ? 0 : model_fwd(int'(v.rs2), v.u2);
      if (est && m_cnt != 64'hFFFF_FFFF) m_cnt++;
      for (int k = 2; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_rw[k] = m_rw[k-1]; m_mr[k] = m_mr[k-1];
      end
      m_v[0]  = squash ? 1'b0 : v.idv;
      m_rd[0] = squash ? 0 : int'(v.rd);
      m_rw[0] = squash ? 1'b0 : v.rw;
      m_mr[0] = squash ? 1'b0 : v.mr;
      nbub = !m_v[0];
    end
    @(posedge clk);
    #1;
    check($sformatf("%s ForwardA", tag), 64'(ForwardA), 64'(tab ? int'(v.efa) : nfa));
    check($sformatf("%s ForwardB", tag), 64'(ForwardB), 64'(tab ? int'(v.efb) : nfb));
    check($sformatf("%s bubble", tag), 64'(bubble), 64'(tab ? v.ebub : nbub));
`ifdef HAZARD_STATS_EN
    check($sformatf("%s stall_count", tag), 64'(stall_count), 64'(m_cnt));
`endif
  endtask

  vec_t tab[21];
  vec_t rv;

  initial begin
    // clr idv rs1 rs2 u1 u2 rd rw mr fl | stall fa fb bubble
    tab[0]  = mk(0,1,  1, 2,1,1,  5,1,0,0, 0,0,0,0); // ADD x5
    tab[1]  = mk(0,1,  5, 6,1,1,  8,1,0,0, 0,2,0,0); // use x5 back-to-back
    tab[2]  = mk(0,0,  0, 0,0,0,  0,0,0,0, 0,0,0,1); // NOP
    tab[3]  = mk(0,1,  0, 0,0,0,  5,1,0,0, 0,0,0,0); // ADD x5
    tab[4]  = mk(0,0,  0, 0,0,0,  0,0,0,0, 0,0,0,1); // NOP
    tab[5]  = mk(0,1,  9, 5,1,1, 10,1,0,0, 0,0,1,0); // SUB rs2=x5
    tab[6]  = mk(0,1,  2, 0,1,0,  7,1,1,0, 0,0,0,0); // LW x7
    tab[7]  = mk(0,1,  7,10,1,1, 11,1,0,0, 1,0,0,1); // use x7: stall
    tab[8]  = mk(0,1,  7,10,1,1, 11,1,0,0, 0,1,0,0); // replay: from WB
    tab[9]  = mk(0,1,  0, 0,0,0,  3,1,0,0, 0,0,0,0); // ADD x3
    tab[10] = mk(0,1,  0, 0,0,0,  3,1,0,0, 0,0,0,0); // ADD x3
    tab[11] = mk(0,1,  3, 3,1,1, 12,1,0,0, 0,2,2,0); // nearest wins
    tab[12] = mk(0,1,  0, 0,0,0,  0,1,0,0, 0,0,0,0); // write x0
    tab[13] = mk(0,1,  0, 0,1,1,  0,1,0,0, 0,0,0,0); // read x0
    tab[14] = mk(0,1,  0, 0,0,0,  0,1,1,0, 0,0,0,0); // LW x0
    tab[15] = mk(0,1,  0, 0,1,1,  0,1,0,0, 0,0,0,0); // read x0: no stall
    tab[16] = mk(0,1,  0, 0,0,0,  4,1,1,0, 0,0,0,0); // LW x4
    tab[17] = mk(0,1,  4, 0,1,0, 13,1,0,1, 0,0,0,1); // load-use with flush
    tab[18] = mk(0,1,  0, 4,0,1, 13,1,0,0, 0,0,1,0); // LW x4 now in MEM
    tab[19] = mk(0,0,  0, 0,0,0,  0,0,0,0, 0,0,0,1); // NOP
    tab[20] = mk(0,1, 13,13,0,1, 14,1,0,0, 0,0,1,0); // unused rs1 ignored

    clr = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0; id_rd = '0; id_RegWrite = 1'b0; id_MemRead = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ForwardA", 64'(ForwardA), 64'd0);
    check("reset ForwardB", 64'(ForwardB), 64'd0);
    check("reset bubble", 64'(bubble), 64'd1);
    check("reset stall", 64'(stall), 64'd0);
`ifdef HAZARD_STATS_EN
    check("reset stall_count", 64'(stall_count), 64'd0);
`endif

    for (int i = 0; i < 21; i++) begin
      step(tab[i], 1'b1, $sformatf("vec%0d", i));
    end

    // Clear asserted while a load-use stall is active.
    step(mk(0,1, 0,0,0,0, 7,1,1,0, 0,0,0,0), 1'b1, "clrseq_lw");
    step(mk(1,1, 7,0,1,0, 9,1,0,0, 1,0,0,1), 1'b1, "clrseq_clr");
    step(mk(0,1, 7,0,1,0, 9,1,0,0, 0,0,0,0), 1'b1, "clrseq_after");

    // Randomized traffic on a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      rv.clr  = ($urandom_range(0, 49) == 0);
      rv.idv  = ($urandom_range(0, 4) != 0);
      rv.rs1  = 5'($urandom_range(0, 5));
      rv.rs2  = 5'($urandom_range(0, 5));
      rv.u1   = ($urandom_range(0, 3) != 0);
      rv.u2   = ($urandom_range(0, 1) != 0);
      rv.rd   = 5'($urandom_range(0, 5));
      rv.rw   = ($urandom_range(0, 4) != 0);
      rv.mr   = ($urandom_range(0, 2) == 0);
      rv.fl   = ($urandom_range(0, 7) == 0);
      rv.est  = 1'b0; rv.efa = '0; rv.efb = '0; rv.ebub = 1'b0;
      step(rv, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
